// File: rtl/riscv_lsu_pkg.sv
// Shared load-store unit types: access-size codes, FSM states, timeout default
// and the alignment/legality check applied to incoming requests.
package riscv_lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  localparam int unsigned LSU_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_RESP,
    LSU_DONE
  } lsu_state_e;

  // True when the size code is illegal or the address is misaligned for it
  function automatic logic lsu_check_fail(input logic [2:0] size, input logic [1:0] off);
    logic fail;
    case (size)
      LDST_B, LDST_BU: fail = 1'b0;
      LDST_H, LDST_HU: fail = off[0];
      LDST_W:          fail = (off != 2'b00);
      default:         fail = 1'b1;
    endcase
    return fail;
  endfunction

endpackage

// File: rtl/riscv_lsu_fmt.sv
// Combinational data formatting for the LSU: store lane replication and byte
// enables, plus load byte/half extraction with sign or zero extension.
module riscv_lsu_fmt
  import riscv_lsu_pkg::*;
(
  input  logic        st_we_i,
  input  logic [2:0]  st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  logic [2:0]  ld_size_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store side: loads always use a full-word enable and zero write data
  always_comb begin
    st_be_o    = '1;
    st_wdata_o = '0;
    if (st_we_i) begin
      case (st_size_i)
        LDST_B, LDST_BU: begin
          st_be_o    = 4'b0001 << st_off_i;
          st_wdata_o = {4{st_data_i[7:0]}};
        end
        LDST_H, LDST_HU: begin
          st_be_o    = st_off_i[1] ? 4'b1100 : 4'b0011;
          st_wdata_o = {2{st_data_i[15:0]}};
        end
        default: begin
          st_be_o    = 4'b1111;
          st_wdata_o = st_data_i;
        end
      endcase
    end
  end

  // Load side: pick the addressed lane, then extend according to size
  always_comb begin
    ld_byte = ld_rdata_i[{ld_off_i, 3'b000} +: 8];
    ld_half = ld_off_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
    case (ld_size_i)
      LDST_B:  ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      LDST_BU: ld_data_o = {24'b0, ld_byte};
      LDST_H:  ld_data_o = {{16{ld_half[15]}}, ld_half};
      LDST_HU: ld_data_o = {16'b0, ld_half};
      default: ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load-store unit: checks decoder requests, runs the req/gnt/rvalid handshake
// with data memory, stalls the core for the duration and returns load data.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic        lsu_stall_req_o,
  output logic [31:0] lsu_data_o,
  output logic        lsu_err_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i
);

  lsu_state_e  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        check_fail, accept, tmo_hit, tmo_abort;

  logic        we_q;
  logic [2:0]  size_q;
  logic [1:0]  off_q;
  logic        data_req_q, data_req_d;
  logic        data_we_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q, wdata_q;
  logic        err_q, err_d;
  logic [31:0] ldata_q, ldata_d;

  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata, fmt_ldata;

  assign check_fail = (state_q == LSU_IDLE) && lsu_check_fail(lsu_size_i, lsu_addr_i[1:0]);
  assign accept     = (state_q == LSU_IDLE) && lsu_req_i && !check_fail;
  assign tmo_hit    = (TIMEOUT_CYCLES != 0) && (state_q inside {LSU_REQ, LSU_RESP})
                      && ((cnt_q + 32'd1) == TIMEOUT_CYCLES);

  riscv_lsu_fmt u_fmt (
    .st_we_i    (lsu_we_i),
    .st_size_i  (lsu_size_i),
    .st_off_i   (lsu_addr_i[1:0]),
    .st_data_i  (lsu_data_i),
    .st_be_o    (fmt_be),
    .st_wdata_o (fmt_wdata),
    .ld_size_i  (size_q),
    .ld_off_i   (off_q),
    .ld_rdata_i (data_rdata_i),
    .ld_data_o  (fmt_ldata)
  );

  // State and per-state cycle counter
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= LSU_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; a grant or response takes priority over a same-cycle timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: if (accept) state_d = LSU_REQ;
      LSU_REQ: begin
        if (data_gnt_i)   state_d = LSU_RESP;
        else if (tmo_hit) state_d = LSU_DONE;
      end
      LSU_RESP: begin
        if (data_rvalid_i) state_d = LSU_DONE;
        else if (tmo_hit)  state_d = LSU_DONE;
      end
      default: state_d = LSU_IDLE;
    endcase
    // Counter restarts on every state entry and only runs while waiting on memory
    if ((state_d != state_q) || !(state_q inside {LSU_REQ, LSU_RESP})) cnt_d = '0;
    else                                                               cnt_d = cnt_q + 32'd1;
  end

  // Outputs: combinational stall plus next values of the registered outputs
  always_comb begin
    lsu_stall_req_o = lsu_req_i && !check_fail && (state_q != LSU_DONE);
    tmo_abort       = tmo_hit && (((state_q == LSU_REQ) && !data_gnt_i) ||
                                  ((state_q == LSU_RESP) && !data_rvalid_i));
    data_req_d      = (state_d == LSU_REQ);
    err_d           = (lsu_req_i && check_fail) || tmo_abort;
    ldata_d         = ldata_q;
    if ((state_q == LSU_RESP) && data_rvalid_i && !we_q) ldata_d = fmt_ldata;
  end

  // Registered memory interface, latched request and load result
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      we_q       <= 1'b0;
      size_q     <= '0;
      off_q      <= '0;
      data_req_q <= 1'b0;
      data_we_q  <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      ldata_q    <= '0;
    end else begin
      data_req_q <= data_req_d;
      err_q      <= err_d;
      ldata_q    <= ldata_d;
      if (accept) begin
        we_q      <= lsu_we_i;
        size_q    <= lsu_size_i;
        off_q     <= lsu_addr_i[1:0];
        data_we_q <= lsu_we_i;
        be_q      <= fmt_be;
        addr_q    <= {lsu_addr_i[31:2], 2'b00};
        wdata_q   <= fmt_wdata;
      end
    end
  end

  assign data_req_o   = data_req_q;
  assign data_we_o    = data_we_q;
  assign data_be_o    = be_q;
  assign data_addr_o  = addr_q;
  assign data_wdata_o = wdata_q;
  assign lsu_err_o    = err_q;
  assign lsu_data_o   = ldata_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: directed cases, randomized accesses with
// random memory latency, timeout and mid-access reset, checked against a
// behavioural model; the formatter is also exercised on its own.
module tb_riscv_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arstn;
  logic        lsu_req, lsu_we;
  logic [2:0]  lsu_size;
  logic [31:0] lsu_addr, lsu_data;
  logic        stall, err, dreq, dwe;
  logic [3:0]  dbe;
  logic [31:0] ldata, daddr, dwdata;
  logic        gnt, rvalid;
  logic [31:0] rdata;

  logic        t_req, t_we;
  logic [2:0]  t_size;
  logic [31:0] t_addr, t_wd;
  logic        t_stall, t_err, t_dreq, t_dwe;
  logic [3:0]  t_be;
  logic [31:0] t_ldata, t_daddr, t_dwdata;
  logic        t_gnt, t_rvalid;
  logic [31:0] t_rdata;

  logic        f_we;
  logic [2:0]  f_size;
  logic [1:0]  f_off;
  logic [31:0] f_d, f_rd, f_wdata, f_ld;
  logic [3:0]  f_be;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_ldata = '0;

  riscv_lsu dut (
    .clk_i(clk), .arstn_i(arstn),
    .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_size_i(lsu_size),
    .lsu_addr_i(lsu_addr), .lsu_data_i(lsu_data),
    .lsu_stall_req_o(stall), .lsu_data_o(ldata), .lsu_err_o(err),
    .data_req_o(dreq), .data_we_o(dwe), .data_be_o(dbe),
    .data_addr_o(daddr), .data_wdata_o(dwdata),
    .data_gnt_i(gnt), .data_rvalid_i(rvalid), .data_rdata_i(rdata)
  );

  riscv_lsu #(.TIMEOUT_CYCLES(8)) dut_to (
    .clk_i(clk), .arstn_i(arstn),
    .lsu_req_i(t_req), .lsu_we_i(t_we), .lsu_size_i(t_size),
    .lsu_addr_i(t_addr), .lsu_data_i(t_wd),
    .lsu_stall_req_o(t_stall), .lsu_data_o(t_ldata), .lsu_err_o(t_err),
    .data_req_o(t_dreq), .data_we_o(t_dwe), .data_be_o(t_be),
    .data_addr_o(t_daddr), .data_wdata_o(t_dwdata),
    .data_gnt_i(t_gnt), .data_rvalid_i(t_rvalid), .data_rdata_i(t_rdata)
  );

  riscv_lsu_fmt u_fmt (
    .st_we_i(f_we), .st_size_i(f_size), .st_off_i(f_off), .st_data_i(f_d),
    .st_be_o(f_be), .st_wdata_o(f_wdata),
    .ld_size_i(f_size), .ld_off_i(f_off), .ld_rdata_i(f_rd), .ld_data_o(f_ld)
  );

  // ---------------- behavioural reference model ----------------
  function automatic logic m_fail(input logic [2:0] sz, input logic [1:0] off);
    return (sz == 3'd3) || (sz == 3'd6) || (sz == 3'd7) ||
           (((sz == 3'd1) || (sz == 3'd5)) && (off % 2 == 1)) ||
           ((sz == 3'd2) && (off != 2'd0));
  endfunction

  function automatic logic [3:0] m_be(input logic we, input logic [2:0] sz, input logic [1:0] off);
    logic [31:0] v;
    if (!we) return 4'hF;
    case (sz)
      3'd0:    v = 32'd1 << off;
      3'd1:    v = 32'd3 << off;
      default: v = 32'd15;
    endcase
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic we, input logic [2:0] sz, input logic [31:0] d);
    if (!we) return 32'd0;
    case (sz)
      3'd0:    return (d & 32'hFF) * 32'h0101_0101;
      3'd1:    return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] sz, input logic [1:0] off, input logic [31:0] rd);
    logic [31:0] v, b, h;
    v = rd >> (8 * int'(off));
    b = v & 32'hFF;
    h = v & 32'hFFFF;
    case (sz)
      3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      default: return rd;
    endcase
  endfunction

  // ---------------- one complete access on the default-timeout DUT ----------------
  // Called just after a rising edge with the DUT idle. gw = cycles gnt is withheld,
  // rw = RESP cycles before rvalid, rvg = also raise rvalid in the grant cycle.
  task automatic run_access(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rd,
                            input int gw, input int rw, input logic rvg);
    int stall_cnt = 0;
    int req_cnt = 0;
    lsu_req = 1'b1; lsu_we = we; lsu_size = sz; lsu_addr = addr; lsu_data = wd;
    gnt = 1'b0; rvalid = 1'b0;
    if (m_fail(sz, addr[1:0])) begin
      @(negedge clk);
      n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL bad_req_stall: got %b expected 0 (sz=%0d addr=%h)", stall, sz, addr); end
      n_tests++; if (dreq !== 1'b0) begin n_fail++; $display("FAIL bad_req_dreq0: got %b expected 0", dreq); end
      @(posedge clk); #1; lsu_req = 1'b0;
      @(negedge clk);
      n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL bad_req_err: got %b expected 1 (sz=%0d addr=%h)", err, sz, addr); end
      n_tests++; if (dreq !== 1'b0) begin n_fail++; $display("FAIL bad_req_dreq1: got %b expected 0", dreq); end
      @(posedge clk); #1;
      @(negedge clk);
      n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL bad_req_err_len: got %b expected 0", err); end
      @(posedge clk); #1;
      return;
    end
    @(negedge clk);
    if (stall === 1'b1) stall_cnt++;
    n_tests++; if (dreq !== 1'b0) begin n_fail++; $display("FAIL idle_dreq: got %b expected 0", dreq); end
    @(posedge clk); #1;
    for (int i = 0; i <= gw; i++) begin
      gnt    = (i == gw);
      rvalid = (i == gw) ? rvg : 1'($urandom_range(0, 1));
      rdata  = $urandom;
      @(negedge clk);
      if (stall === 1'b1) stall_cnt++;
      if (dreq === 1'b1) req_cnt++;
      if (i == 0) begin
        n_tests++; if (daddr !== (addr & 32'hFFFF_FFFC)) begin n_fail++; $display("FAIL addr: got %h expected %h", daddr, addr & 32'hFFFF_FFFC); end
        n_tests++; if (dbe !== m_be(we, sz, addr[1:0])) begin n_fail++; $display("FAIL be: got %b expected %b (sz=%0d addr=%h)", dbe, m_be(we, sz, addr[1:0]), sz, addr); end
        n_tests++; if (dwdata !== m_wdata(we, sz, wd)) begin n_fail++; $display("FAIL wdata: got %h expected %h", dwdata, m_wdata(we, sz, wd)); end
        n_tests++; if (dwe !== we) begin n_fail++; $display("FAIL we: got %b expected %b", dwe, we); end
      end
      @(posedge clk); #1;
    end
    gnt = 1'b0;
    for (int i = 0; i <= rw; i++) begin
      rvalid = (i == rw);
      rdata  = (i == rw) ? rd : $urandom;
      @(negedge clk);
      if (stall === 1'b1) stall_cnt++;
      if (dreq === 1'b1) req_cnt++;
      @(posedge clk); #1;
    end
    rvalid = 1'b0;
    rdata  = $urandom;
    if (!we) exp_ldata = m_load(sz, addr[1:0], rd);
    @(negedge clk);
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL done_stall: got %b expected 0", stall); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL done_err: got %b expected 0", err); end
    n_tests++; if (ldata !== exp_ldata) begin n_fail++; $display("FAIL ldata: got %h expected %h (sz=%0d addr=%h we=%b)", ldata, exp_ldata, sz, addr, we); end
    n_tests++; if (stall_cnt != 3 + gw + rw) begin n_fail++; $display("FAIL stall_len: got %0d expected %0d", stall_cnt, 3 + gw + rw); end
    n_tests++; if (req_cnt != gw + 1) begin n_fail++; $display("FAIL req_len: got %0d expected %0d", req_cnt, gw + 1); end
    @(posedge clk); #1;
    lsu_req = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    n_tests++; if ({dreq, dwe, err, stall} !== 4'b0) begin n_fail++; $display("FAIL rst_ctrl: got %b expected 0000", {dreq, dwe, err, stall}); end
    n_tests++; if (dbe !== 4'b0) begin n_fail++; $display("FAIL rst_be: got %b expected 0000", dbe); end
    n_tests++; if ({daddr, dwdata, ldata} !== 96'b0) begin n_fail++; $display("FAIL rst_data: got %h %h %h expected 0", daddr, dwdata, ldata); end
    n_tests++; if ({t_dreq, t_err, t_ldata} !== 34'b0) begin n_fail++; $display("FAIL rst_to: got %b %b %h expected 0", t_dreq, t_err, t_ldata); end
    @(negedge clk); arstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fmt;
    logic [2:0] szs [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int k = 0; k < 40; k++) begin
      f_we   = 1'($urandom_range(0, 1));
      f_size = f_we ? szs[$urandom_range(0, 2)] : szs[$urandom_range(0, 4)];
      f_off  = 2'($urandom_range(0, 3));
      if (f_size == 3'd1 || f_size == 3'd5) f_off[0] = 1'b0;
      if (f_size == 3'd2) f_off = 2'd0;
      f_d  = $urandom;
      f_rd = $urandom;
      #1;
      n_tests++; if (f_be !== m_be(f_we, f_size, f_off)) begin n_fail++; $display("FAIL fmt_be: got %b expected %b", f_be, m_be(f_we, f_size, f_off)); end
      n_tests++; if (f_wdata !== m_wdata(f_we, f_size, f_d)) begin n_fail++; $display("FAIL fmt_wdata: got %h expected %h", f_wdata, m_wdata(f_we, f_size, f_d)); end
      n_tests++; if (f_ld !== m_load(f_size, f_off, f_rd)) begin n_fail++; $display("FAIL fmt_ld: got %h expected %h", f_ld, m_load(f_size, f_off, f_rd)); end
    end
  endtask

  task automatic test_directed;
    run_access(1'b0, 3'd0, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 0, 1'b0);
    run_access(1'b0, 3'd5, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 0, 1'b0);
    run_access(1'b0, 3'd1, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 0, 1'b0);
    run_access(1'b1, 3'd0, 32'h0000_0010, 32'h0000_00AB, 32'h0, 0, 0, 1'b0);
    run_access(1'b1, 3'd1, 32'h0000_0012, 32'h0000_BEEF, 32'h0, 0, 0, 1'b0);
    run_access(1'b0, 3'd2, 32'h0000_0006, 32'h0, 32'h0, 0, 0, 1'b0);
    run_access(1'b0, 3'd3, 32'h0000_0000, 32'h0, 32'h0, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_access(1'b0, 3'd2, 32'h0000_0400, 32'h0, 32'hCAFE_F00D, 4, 1, 1'b1);
    run_access(1'b0, 3'd4, 32'h0000_0401, 32'h0, 32'h1234_F6A5, 2, 3, 1'b1);
  endtask

  task automatic test_random;
    for (int k = 0; k < 40; k++) begin
      logic w;
      logic [2:0] sz;
      logic [31:0] a;
      w  = 1'($urandom_range(0, 1));
      sz = 3'($urandom_range(0, 7));
      if (w && (sz == 3'd4 || sz == 3'd5)) sz = sz - 3'd4;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 3'd1 || sz == 3'd5) a[0] = 1'b0;
        if (sz == 3'd2) a[1:0] = 2'b00;
      end
      run_access(w, sz, a, $urandom, $urandom, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
  endtask

  // s=0: grant never arrives; s=1: granted at once but no response
  task automatic test_timeout;
    for (int s = 0; s < 2; s++) begin
      int stall_cnt = 0;
      int req_cnt = 0;
      logic seen_done = 1'b0;
      t_req = 1'b1; t_we = 1'b0; t_size = 3'd2; t_addr = 32'h0000_0040;
      for (int i = 0; i < 25 && !seen_done; i++) begin
        t_gnt    = (s == 1) && (i == 1);
        t_rdata  = $urandom;
        @(negedge clk);
        if (t_dreq === 1'b1) req_cnt++;
        if (t_stall === 1'b1) stall_cnt++;
        else begin
          seen_done = 1'b1;
          n_tests++; if (t_err !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b expected 1 (s=%0d)", t_err, s); end
          n_tests++; if (t_ldata !== 32'h0) begin n_fail++; $display("FAIL tmo_ldata: got %h expected 0", t_ldata); end
          n_tests++; if (t_dreq !== 1'b0) begin n_fail++; $display("FAIL tmo_dreq: got %b expected 0", t_dreq); end
        end
        @(posedge clk); #1;
      end
      t_gnt = 1'b0;
      n_tests++; if (seen_done !== 1'b1) begin n_fail++; $display("FAIL tmo_end: got %b expected 1 (stall never dropped)", seen_done); end
      n_tests++; if (stall_cnt != ((s == 0) ? 9 : 10)) begin n_fail++; $display("FAIL tmo_stall_len: got %0d expected %0d", stall_cnt, (s == 0) ? 9 : 10); end
      n_tests++; if (req_cnt != ((s == 0) ? 8 : 1)) begin n_fail++; $display("FAIL tmo_req_len: got %0d expected %0d", req_cnt, (s == 0) ? 8 : 1); end
      t_req = 1'b0;
      @(negedge clk);
      n_tests++; if ({t_err, t_dreq, t_stall} !== 3'b0) begin n_fail++; $display("FAIL tmo_idle: got %b expected 000", {t_err, t_dreq, t_stall}); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 3'd2; lsu_addr = 32'h0000_0100; lsu_data = 32'h0;
    @(posedge clk); #1;
    gnt = 1'b1;
    @(posedge clk); #1;
    gnt = 1'b0;
    #2;
    arstn = 1'b0; lsu_req = 1'b0;
    #1;
    n_tests++; if ({dreq, dwe, err, stall} !== 4'b0) begin n_fail++; $display("FAIL mid_rst_ctrl: got %b expected 0000", {dreq, dwe, err, stall}); end
    n_tests++; if ({dbe, daddr, dwdata, ldata} !== 100'b0) begin n_fail++; $display("FAIL mid_rst_data: got %b %h %h %h expected 0", dbe, daddr, dwdata, ldata); end
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    @(negedge clk); arstn = 1'b1; rvalid = 1'b0;
    exp_ldata = '0;
    @(negedge clk);
    n_tests++; if ({err, ldata} !== 33'b0) begin n_fail++; $display("FAIL mid_rst_after: got %b %h expected 0", err, ldata); end
    @(posedge clk); #1;
    run_access(1'b0, 3'd0, 32'h0000_3001, 32'h0, 32'h0000_7F00, 1, 0, 1'b0);
  endtask

  initial begin
    arstn = 1'b0;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_size = '0; lsu_addr = '0; lsu_data = '0;
    gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    t_req = 1'b0; t_we = 1'b0; t_size = '0; t_addr = '0; t_wd = '0;
    t_gnt = 1'b0; t_rvalid = 1'b0; t_rdata = '0;
    f_we = 1'b0; f_size = '0; f_off = '0; f_d = '0; f_rd = '0;
    test_reset();
    test_fmt();
    test_directed();
    test_back_to_back();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
